radar_roi_reader: RTL and testbench

RADAR_ROI_READER -- requirements
Module: radar_roi_reader

---
 rtl/radar_roi_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_radar_roi_reader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_roi_reader.sv
// Reads a rectangular ROI from pixel memory in raster order, one channel or the sum of all channels per beat.
// Latency: first beat 2 cycles after start (single) or CH_NUM+1 cycles after (sum); a returning beat bypasses an empty buffer.
// Backpressure: 2-entry output buffer; beat-completing reads stall while buffered + in-flight beats would exceed 2.
module radar_roi_reader #(
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8,
    parameter int CH_NUM = 4,
    parameter int PIX_W  = 16,
    localparam int CH_W  = $clog2(CH_NUM),
    localparam int AW    = CH_W + ROW_W + COL_W,
    localparam int OW    = PIX_W + CH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROW_W-1:0] row_idx1,
    input  logic [ROW_W-1:0] row_idx2,
    input  logic [COL_W-1:0] col_idx1,
    input  logic [COL_W-1:0] col_idx2,
    input  logic [CH_W-1:0]  channel_num,
    input  logic             sum_mode,
    output logic             busy,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [PIX_W-1:0] mem_rd_data,
    input  logic             pixel_ready,
    output logic             data_vaild,
    output logic             data_start,
    output logic             data_end,
    output logic [OW-1:0]    pixel_out
);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0] rmin_q, rmax_q, row_q;
    logic [COL_W-1:0] cmin_q, cmax_q, col_q;
    logic [CH_W-1:0]  ch_sel_q, ch_q;
    logic             sum_q;
    logic             first_q;

    // Read issued last cycle; its data is on mem_rd_data this cycle.
    logic             pend_vld_q;
    logic             pend_beat_q;
    logic             pend_clr_q;
    logic             pend_start_q;
    logic             pend_end_q;
    logic [OW-1:0]    acc_q;

    logic [OW-1:0]    buf_pix_q [2];
    logic [1:0]       buf_start_q;
    logic [1:0]       buf_end_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;

    logic             accept;
    logic             last_ch;
    logic             last_rd;
    logic             room;
    logic [OW-1:0]    acc_base;
    logic [OW-1:0]    beat_val;
    logic             push;
    logic             buf_pop;
    logic             pop;

    assign accept   = (state_q == S_IDLE) && start;
    assign last_ch  = !sum_q || (ch_q == CH_LAST);
    assign last_rd  = last_ch && (row_q == rmax_q) && (col_q == cmax_q);
    assign room     = ({1'b0, cnt_q} + {2'b00, pend_beat_q}) < 3'd2;
    assign acc_base = pend_clr_q ? '0 : acc_q;
    assign beat_val = acc_base + {{CH_W{1'b0}}, mem_rd_data};
    assign mem_addr = {(sum_q ? ch_q : ch_sel_q), row_q, col_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (mem_rd_en && last_rd) state_d = S_DRAIN;
            S_DRAIN: if (pop && data_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reads that only feed the accumulator never need buffer room.
    always_comb begin
        busy      = (state_q != S_IDLE);
        mem_rd_en = (state_q == S_RUN) && (!last_ch || room);
    end

    always_comb begin
        data_vaild = 1'b0;
        data_start = 1'b0;
        data_end   = 1'b0;
        pixel_out  = '0;
        if (cnt_q != 2'd0) begin
            data_vaild = 1'b1;
            data_start = buf_start_q[rd_ptr_q];
            data_end   = buf_end_q[rd_ptr_q];
            pixel_out  = buf_pix_q[rd_ptr_q];
        end else if (pend_beat_q) begin
            data_vaild = 1'b1;
            data_start = pend_start_q;
            data_end   = pend_end_q;
            pixel_out  = beat_val;
        end
    end

    assign pop     = data_vaild && pixel_ready;
    assign buf_pop = pop && (cnt_q != 2'd0);
    assign push    = pend_beat_q && !((cnt_q == 2'd0) && pixel_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rmin_q   <= '0;
            rmax_q   <= '0;
            cmin_q   <= '0;
            cmax_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            ch_q     <= '0;
            ch_sel_q <= '0;
            sum_q    <= 1'b0;
            first_q  <= 1'b0;
        end else if (accept) begin
            rmin_q   <= (row_idx1 < row_idx2) ? row_idx1 : row_idx2;
            rmax_q   <= (row_idx1 < row_idx2) ? row_idx2 : row_idx1;
            cmin_q   <= (col_idx1 < col_idx2) ? col_idx1 : col_idx2;
            cmax_q   <= (col_idx1 < col_idx2) ? col_idx2 : col_idx1;
            row_q    <= (row_idx1 < row_idx2) ? row_idx1 : row_idx2;
            col_q    <= (col_idx1 < col_idx2) ? col_idx1 : col_idx2;
            ch_q     <= '0;
            ch_sel_q <= channel_num;
            sum_q    <= sum_mode;
            first_q  <= 1'b1;
        end else if (mem_rd_en) begin
            if (last_ch) begin
                first_q <= 1'b0;
            end
            // The final read leaves the counters parked so nothing steps past rmax/cmax.
            if (!last_rd) begin
                if (!last_ch) begin
                    ch_q <= ch_q + 1'b1;
                end else begin
                    ch_q <= '0;
                    if (col_q == cmax_q) begin
                        col_q <= cmin_q;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld_q   <= 1'b0;
            pend_beat_q  <= 1'b0;
            pend_clr_q   <= 1'b0;
            pend_start_q <= 1'b0;
            pend_end_q   <= 1'b0;
            acc_q        <= '0;
        end else begin
            pend_vld_q   <= mem_rd_en;
            pend_beat_q  <= mem_rd_en && last_ch;
            pend_clr_q   <= !sum_q || (ch_q == '0);
            pend_start_q <= first_q && last_ch;
            pend_end_q   <= last_rd;
            if (pend_vld_q) begin
                acc_q <= beat_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_pix_q[i] <= '0;
            end
            buf_start_q <= '0;
            buf_end_q   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (push) begin
                buf_pix_q[wr_ptr_q]   <= beat_val;
                buf_start_q[wr_ptr_q] <= pend_start_q;
                buf_end_q[wr_ptr_q]   <= pend_end_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (buf_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, buf_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_radar_roi_reader.sv
// Directed bench for radar_roi_reader: vector table of ROIs plus stall, reset-abort, busy-start and saturation sequences.
module tb_radar_roi_reader;

    localparam int ROW_W = 8, COL_W = 8, CH_NUM = 4, PIX_W = 16;
    localparam int CH_W = 2, AW = 18, OW = 18;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [ROW_W-1:0] row_idx1 = '0, row_idx2 = '0;
    logic [COL_W-1:0] col_idx1 = '0, col_idx2 = '0;
    logic [CH_W-1:0]  channel_num = '0;
    logic             sum_mode = 1'b0;
    logic             busy, mem_rd_en, data_vaild, data_start, data_end;
    logic [AW-1:0]    mem_addr;
    logic [PIX_W-1:0] mem_rd_data = '0;
    logic             pixel_ready = 1'b1;
    logic [OW-1:0]    pixel_out;

    radar_roi_reader #(.ROW_W(ROW_W), .COL_W(COL_W), .CH_NUM(CH_NUM), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .row_idx1(row_idx1), .row_idx2(row_idx2), .col_idx1(col_idx1), .col_idx2(col_idx2),
        .channel_num(channel_num), .sum_mode(sum_mode), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pixel_ready(pixel_ready), .data_vaild(data_vaild), .data_start(data_start),
        .data_end(data_end), .pixel_out(pixel_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mem_ff = 1'b0;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;

    logic [OW-1:0] bp_q[$];
    bit            bs_q[$];
    bit            be_q[$];
    int            bc_q[$];
    logic [AW-1:0] ra_q[$];
    int            rc_q[$];

    // Pixel content encodes its own coordinates so ordering errors show up as value errors.
    function automatic logic [15:0] memf(input int ch, input int row, input int col);
        logic [15:0] v;
        v = 16'(row * 256 + col + ch);
        return mem_ff ? 16'hFFFF : v;
    endfunction

    function automatic logic [OW-1:0] model_pix(input int ch, input int sm, input int row, input int col);
        logic [OW-1:0] s;
        s = '0;
        if (sm != 0) begin
            for (int k = 0; k < CH_NUM; k++) s = s + OW'(memf(k, row, col));
        end else begin
            s = OW'(memf(ch, row, col));
        end
        return s;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1 mem_rd_data = m_en ? memf(int'(m_addr[17:16]), int'(m_addr[15:8]), int'(m_addr[7:0])) : 16'h0000;
    end

    always @(negedge clk) begin
        m_en   = mem_rd_en;
        m_addr = mem_addr;
        if (mem_rd_en === 1'b1) begin
            ra_q.push_back(mem_addr);
            rc_q.push_back(cyc);
        end
        if (data_vaild === 1'b1 && pixel_ready === 1'b1) begin
            bp_q.push_back(pixel_out);
            bs_q.push_back(data_start);
            be_q.push_back(data_end);
            bc_q.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic clear_q();
        bp_q.delete(); bs_q.delete(); be_q.delete(); bc_q.delete(); ra_q.delete(); rc_q.delete();
    endtask

    task automatic do_start(input int r1, input int r2, input int c1, input int c2,
                            input int ch, input int sm, output int c0);
        @(posedge clk); #1;
        clear_q();
        row_idx1 = ROW_W'(r1); row_idx2 = ROW_W'(r2);
        col_idx1 = COL_W'(c1); col_idx2 = COL_W'(c2);
        channel_num = CH_W'(ch); sum_mode = (sm != 0);
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int idle_cyc);
        idle_cyc = -1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle_cyc = cyc;
                break;
            end
        end
        if (idle_cyc < 0) begin
            checks++; errors++;
            $display("FAIL busy_timeout actual=busy required=idle");
        end
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 200 && bp_q.size() < n; k++) begin
            @(posedge clk); #1;
        end
        if (bp_q.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_beats actual=%0d required=%0d", bp_q.size(), n);
        end
    endtask

    task automatic check_roi(input string pfx, input int r1, input int r2, input int c1, input int c2,
                             input int ch, input int sm);
        int rmin, rmax, cmin, cmax, idx, nbad, nexp;
        rmin = (r1 < r2) ? r1 : r2; rmax = (r1 < r2) ? r2 : r1;
        cmin = (c1 < c2) ? c1 : c2; cmax = (c1 < c2) ? c2 : c1;
        nexp = (rmax - rmin + 1) * (cmax - cmin + 1);
        chk({pfx, "_nbeats"}, bp_q.size(), nexp);
        idx = 0; nbad = 0;
        for (int r = rmin; r <= rmax; r++) begin
            for (int c = cmin; c <= cmax; c++) begin
                if (idx >= bp_q.size() || bp_q[idx] !== model_pix(ch, sm, r, c)
                    || bs_q[idx] != (idx == 0) || be_q[idx] != (idx == nexp - 1)) nbad++;
                idx++;
            end
        end
        chk({pfx, "_raster_bad"}, nbad, 0);
    endtask

    typedef struct {
        int r1, r2, c1, c2, ch, sm, nb;
        logic [31:0] fpix, lpix, faddr, laddr;
    } vec_t;

    vec_t vt[6];

    initial begin
        int c0, ci, lat, per;
        string p;
        vt[0] = '{2, 3, 5, 6, 1, 0, 4, 32'h00206, 32'h00307, 32'h10205, 32'h10306};
        vt[1] = '{3, 2, 6, 5, 1, 0, 4, 32'h00206, 32'h00307, 32'h10205, 32'h10306};
        vt[2] = '{0, 0, 0, 0, 0, 1, 1, 32'h00006, 32'h00006, 32'h00000, 32'h30000};
        vt[3] = '{255, 254, 255, 255, 3, 0, 2, 32'h0FF02, 32'h00002, 32'h3FEFF, 32'h3FFFF};
        vt[4] = '{1, 1, 0, 2, 0, 1, 3, 32'h00406, 32'h0040E, 32'h00100, 32'h30102};
        vt[5] = '{0, 1, 255, 254, 2, 0, 4, 32'h00100, 32'h00201, 32'h200FE, 32'h201FF};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_vld", data_vaild, 0);
        chk("rst_start", data_start, 0);
        chk("rst_end", data_end, 0);
        chk("rst_pix", pixel_out, 0);
        chk("rst_addr", mem_addr, 0);

        for (int i = 0; i < 6; i++) begin
            p = $sformatf("v%0d", i);
            do_start(vt[i].r1, vt[i].r2, vt[i].c1, vt[i].c2, vt[i].ch, vt[i].sm, c0);
            wait_idle(ci);
            lat = (vt[i].sm != 0) ? CH_NUM + 1 : 2;
            per = (vt[i].sm != 0) ? CH_NUM : 1;
            chk({p, "_nb"}, bp_q.size(), vt[i].nb);
            chk({p, "_nrd"}, ra_q.size(), vt[i].nb * per);
            if (bp_q.size() > 0 && ra_q.size() > 0) begin
                chk({p, "_fpix"}, bp_q[0], vt[i].fpix);
                chk({p, "_lpix"}, bp_q[bp_q.size()-1], vt[i].lpix);
                chk({p, "_faddr"}, ra_q[0], vt[i].faddr);
                chk({p, "_laddr"}, ra_q[ra_q.size()-1], vt[i].laddr);
                chk({p, "_rd_lat"}, rc_q[0] - c0, 1);
                chk({p, "_beat_lat"}, bc_q[0] - c0, lat);
                chk({p, "_rate"}, bc_q[bc_q.size()-1] - bc_q[0], (vt[i].nb - 1) * per);
                chk({p, "_busy_fall"}, ci - bc_q[bc_q.size()-1], 1);
            end
            check_roi(p, vt[i].r1, vt[i].r2, vt[i].c1, vt[i].c2, vt[i].ch, vt[i].sm);
        end

        // Saturating sum: four channels of 0xFFFF.
        mem_ff = 1'b1;
        do_start(0, 0, 0, 0, 0, 1, c0);
        wait_idle(ci);
        mem_ff = 1'b0;
        chk("sat_nb", bp_q.size(), 1);
        if (bp_q.size() > 0) begin
            chk("sat_pix", bp_q[0], 32'h3FFFC);
            chk("sat_flags", {be_q[0], bs_q[0]}, 2'b11);
            chk("sat_lat", bc_q[0] - c0, CH_NUM + 1);
        end

        // Five stalled cycles with beat 3, pixel (1,0), at the head.
        do_start(0, 2, 0, 2, 0, 0, c0);
        wait_beats(3);
        pixel_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_vld", s), data_vaild, 1);
            chk($sformatf("stall%0d_pix", s), pixel_out, 32'h00100);
            chk($sformatf("stall%0d_flags", s), {data_end, data_start}, 2'b00);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_occ_le2", s), (ra_q.size() - bp_q.size()) <= 2, 1);
        end
        pixel_ready = 1'b1;
        wait_idle(ci);
        check_roi("stall", 0, 2, 0, 2, 0, 0);

        // Reset after beat 2 of a 4x4, then a 1x1 started in the first cycle out of reset.
        do_start(0, 3, 0, 3, 0, 0, c0);
        wait_beats(3);
        pixel_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pixel_ready = 1'b1;
        clear_q();
        row_idx1 = 8'd5; row_idx2 = 8'd5; col_idx1 = 8'd7; col_idx2 = 8'd7;
        channel_num = 2'd2; sum_mode = 1'b0;
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_vld", data_vaild, 0);
        chk("abort_end", data_end, 0);
        chk("abort_pix", pixel_out, 0);
        chk("abort_addr", mem_addr, 0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(ci);
        chk("post_rst_nb", bp_q.size(), 1);
        if (bp_q.size() > 0) begin
            chk("post_rst_pix", bp_q[0], 32'h00509);
            chk("post_rst_flags", {be_q[0], bs_q[0]}, 2'b11);
            chk("post_rst_lat", bc_q[0] - c0, 2);
        end

        // A start pulse with different bounds while busy must change nothing.
        do_start(4, 5, 9, 10, 3, 0, c0);
        row_idx1 = '0; row_idx2 = '0; col_idx1 = '0; col_idx2 = '0;
        channel_num = '0; sum_mode = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(ci);
        repeat (6) @(negedge clk);
        chk("busy_start_idle", busy, 0);
        check_roi("busy_start", 4, 5, 9, 10, 3, 0);
        if (bp_q.size() > 0) chk("busy_start_fpix", bp_q[0], 32'h0040C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
